// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_pkg
// Purpose  : Shared definitions for the memory pipeline stage: FSM state
//            encoding, access-size codes, fault codes and an alignment helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Access-size codes; code 3 is reserved and behaves as a word access.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Fault pulse codes.
  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

  // Bytes are always aligned, halves need bit 0 clear, words (and the
  // reserved code) need both low bits clear.
  function automatic logic is_aligned(input logic [1:0] size,
                                      input logic [1:0] addr_lo);
    logic ok;
    case (size)
      SZ_BYTE: ok = 1'b1;
      SZ_HALF: ok = ~addr_lo[0];
      default: ok = (addr_lo == 2'b00);
    endcase
    return ok;
  endfunction

endpackage : mem_stage_pkg
`default_nettype wire

// File: rtl/mem_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_align
// Purpose  : Combinational lane steering for the data memory port.
//            Store side: byte enables and lane-replicated write data.
//            Load side : lane extraction with zero/sign extension.
// Ports    : i_size     - access size code
//            i_addr_lo  - byte offset within the word
//            i_signed   - sign-extend loaded byte/half
//            i_wdata    - right-aligned store data
//            i_rdata    - raw word read from memory
//            o_be       - byte enables (little-endian lanes)
//            o_wdata    - replicated store data
//            o_rdata    - extracted, extended load data
// Revision : 1.0 - initial release
// ============================================================================
module mem_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_signed,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [31:0] w_shifted;

  // Bring the addressed lane down to bit 0 before extension.
  assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    o_rdata = i_rdata;
    case (i_size)
      SZ_BYTE: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{i_signed & w_shifted[7]}}, w_shifted[7:0]};
      end
      SZ_HALF: begin
        o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{i_signed & w_shifted[15]}}, w_shifted[15:0]};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
      end
    endcase
  end

endmodule : mem_align
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Pipeline memory stage. ALU results pass straight to writeback;
//            loads/stores are latched and issued to a ready-handshaked data
//            memory, with back-pressure to execute, misalignment detection
//            and a wait timeout.
// Ports    : clk, rst (sync, active-low)
//            *_EX       - operation from execute
//            stall_MEM  - back-pressure to execute
//            dmem_*     - data memory request/response
//            wb_*_WB    - register-file write pulse
//            fault_MEM  - fault pulse (01 misaligned, 10 timeout)
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DMEM_AW = 10,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_EX,
  input  logic               is_mem_EX,
  input  logic               we_EX,
  input  logic [1:0]         size_EX,
  input  logic               signed_EX,
  input  logic [31:0]        addr_EX,
  input  logic [31:0]        wdata_EX,
  input  logic [4:0]         rd_EX,
  output logic               stall_MEM,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [3:0]         dmem_be,
  output logic [31:0]        dmem_wdata,
  input  logic               dmem_ready,
  input  logic [31:0]        dmem_rdata,
  output logic               wb_valid_WB,
  output logic [4:0]         wb_rd_WB,
  output logic [31:0]        wb_data_WB,
  output logic [1:0]         fault_MEM
);

  // Counter value in the last BUSY cycle allowed before the abort.
  localparam logic [3:0] C_CNT_LAST = 4'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                sgn_q, sgn_d;
  logic [DMEM_AW+1:0]  addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [4:0]          rd_q, rd_d;
  logic                wb_valid_q, wb_valid_d;
  logic [4:0]          wb_rd_q, wb_rd_d;
  logic [31:0]         wb_data_q, wb_data_d;
  logic [1:0]          fault_q, fault_d;

  logic [31:0]         w_load_data;
  logic                w_busy;

  assign w_busy = (state_q == ST_BUSY);

  mem_align u_align (
    .i_size    (size_q),
    .i_addr_lo (addr_q[1:0]),
    .i_signed  (sgn_q),
    .i_wdata   (wdata_q),
    .i_rdata   (dmem_rdata),
    .o_be      (dmem_be),
    .o_wdata   (dmem_wdata),
    .o_rdata   (w_load_data)
  );

  // Memory port is driven only from the latched request, so it stays
  // stable for the whole BUSY window regardless of execute's inputs.
  assign dmem_req  = w_busy;
  assign dmem_we   = w_busy & we_q;
  assign dmem_addr = addr_q[DMEM_AW+1:2];

  assign wb_valid_WB = wb_valid_q;
  assign wb_rd_WB    = wb_rd_q;
  assign wb_data_WB  = wb_data_q;
  assign fault_MEM   = fault_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    size_d     = size_q;
    sgn_d      = sgn_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    fault_d    = FAULT_NONE;
    stall_MEM  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_EX) begin
          if (!is_mem_EX) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_EX;
            wb_data_d  = addr_EX;
          end else if (is_aligned(size_EX, addr_EX[1:0])) begin
            // Hold execute in the accepting cycle; it releases only when
            // the access completes or aborts.
            stall_MEM = 1'b1;
            state_d   = ST_BUSY;
            cnt_d     = 4'd0;
            we_d      = we_EX;
            size_d    = size_EX;
            sgn_d     = signed_EX;
            addr_d    = addr_EX[DMEM_AW+1:0];
            wdata_d   = wdata_EX;
            rd_d      = rd_EX;
          end else begin
            fault_d = FAULT_MISALIGN;
          end
        end
      end
      ST_BUSY: begin
        if (dmem_ready) begin
          state_d = ST_IDLE;
          if (!we_q) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = rd_q;
            wb_data_d  = w_load_data;
          end
        end else if (cnt_q == C_CNT_LAST) begin
          // Stall drops here too so execute retires the aborted op
          // instead of re-presenting it in IDLE.
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
          fault_d = FAULT_TIMEOUT;
        end else begin
          stall_MEM = 1'b1;
          cnt_d     = cnt_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      size_q     <= SZ_WORD;
      sgn_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      rd_q       <= 5'd0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= 32'd0;
      fault_q    <= FAULT_NONE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      size_q     <= size_d;
      sgn_q      <= sgn_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      fault_q    <= fault_d;
    end
  end

endmodule : mem_stage
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Self-checking bench for mem_stage: table of single operations
//            (pass-through, misaligned, loads/stores with immediate ready)
//            plus directed sequences for wait states, timeout and reset
//            during an access.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic        req_EX, is_mem_EX, we_EX, signed_EX;
  logic [1:0]  size_EX;
  logic [31:0] addr_EX, wdata_EX;
  logic [4:0]  rd_EX;
  logic        stall_MEM, dmem_req, dmem_we, dmem_ready;
  logic [9:0]  dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic        wb_valid_WB;
  logic [4:0]  wb_rd_WB;
  logic [31:0] wb_data_WB;
  logic [1:0]  fault_MEM;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage #(.DMEM_AW(10), .TIMEOUT(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_EX     (req_EX),
    .is_mem_EX  (is_mem_EX),
    .we_EX      (we_EX),
    .size_EX    (size_EX),
    .signed_EX  (signed_EX),
    .addr_EX    (addr_EX),
    .wdata_EX   (wdata_EX),
    .rd_EX      (rd_EX),
    .stall_MEM  (stall_MEM),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_be    (dmem_be),
    .dmem_wdata (dmem_wdata),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .wb_valid_WB(wb_valid_WB),
    .wb_rd_WB   (wb_rd_WB),
    .wb_data_WB (wb_data_WB),
    .fault_MEM  (fault_MEM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_mem;
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        exp_stall;  // aligned mem op -> accepted, BUSY
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_wb;
    logic [31:0] exp_data;
    logic [1:0]  exp_fault;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_op(input logic m, input logic w, input logic [1:0] s,
                          input logic sg, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] r);
    req_EX = 1'b1; is_mem_EX = m; we_EX = w; size_EX = s;
    signed_EX = sg; addr_EX = a; wdata_EX = wd; rd_EX = r;
  endtask

  initial begin
    //               mem we sz  sg addr          wdata         rdata         rd  stl be       wdata_exp     wb  data          fault
    vecs[0]  = '{1'b0,1'b0,2'd0,1'b0,32'h0000_1234,32'h0,        32'h0,        5'd5, 1'b0,4'b0000,32'h0,        1'b1,32'h0000_1234,2'b00};
    vecs[1]  = '{1'b0,1'b0,2'd2,1'b0,32'hDEAD_BEEF,32'h0,        32'h0,        5'd0, 1'b0,4'b0000,32'h0,        1'b1,32'hDEAD_BEEF,2'b00};
    vecs[2]  = '{1'b1,1'b0,2'd2,1'b0,32'h0000_0102,32'h0,        32'h0,        5'd3, 1'b0,4'b0000,32'h0,        1'b0,32'h0,        2'b01};
    vecs[3]  = '{1'b1,1'b1,2'd1,1'b0,32'h0000_0021,32'hABCD,     32'h0,        5'd0, 1'b0,4'b0000,32'h0,        1'b0,32'h0,        2'b01};
    vecs[4]  = '{1'b1,1'b0,2'd0,1'b1,32'h0000_0103,32'h0,        32'h80FF_0000,5'd7, 1'b1,4'b1000,32'h0,        1'b1,32'hFFFF_FF80,2'b00};
    vecs[5]  = '{1'b1,1'b0,2'd0,1'b0,32'h0000_0101,32'h0,        32'h1234_5678,5'd8, 1'b1,4'b0010,32'h0,        1'b1,32'h0000_0056,2'b00};
    vecs[6]  = '{1'b1,1'b0,2'd1,1'b1,32'h0000_0202,32'h0,        32'h8001_7FFF,5'd9, 1'b1,4'b1100,32'h0,        1'b1,32'hFFFF_8001,2'b00};
    vecs[7]  = '{1'b1,1'b0,2'd1,1'b0,32'h0000_0200,32'h0,        32'h8001_F00D,5'd10,1'b1,4'b0011,32'h0,        1'b1,32'h0000_F00D,2'b00};
    vecs[8]  = '{1'b1,1'b0,2'd2,1'b1,32'h0000_0300,32'h0,        32'hCAFE_BABE,5'd11,1'b1,4'b1111,32'h0,        1'b1,32'hCAFE_BABE,2'b00};
    vecs[9]  = '{1'b1,1'b1,2'd1,1'b0,32'h0000_0022,32'h1234_ABCD,32'h0,        5'd12,1'b1,4'b1100,32'hABCD_ABCD,1'b0,32'h0,        2'b00};
    vecs[10] = '{1'b1,1'b1,2'd0,1'b0,32'h0000_0010,32'h0000_00A5,32'h0,        5'd13,1'b1,4'b0001,32'hA5A5_A5A5,1'b0,32'h0,        2'b00};
    vecs[11] = '{1'b1,1'b1,2'd2,1'b0,32'h0000_03FC,32'h0102_0304,32'h0,        5'd14,1'b1,4'b1111,32'h0102_0304,1'b0,32'h0,        2'b00};
    vecs[12] = '{1'b1,1'b0,2'd3,1'b1,32'h0000_0040,32'h0,        32'h1122_3344,5'd15,1'b1,4'b1111,32'h0,        1'b1,32'h1122_3344,2'b00};
    vecs[13] = '{1'b1,1'b0,2'd3,1'b0,32'h0000_0041,32'h0,        32'h0,        5'd16,1'b0,4'b0000,32'h0,        1'b0,32'h0,        2'b01};
    vecs[14] = '{1'b1,1'b0,2'd0,1'b1,32'h0000_0100,32'h0,        32'h0000_007F,5'd17,1'b1,4'b0001,32'h0,        1'b1,32'h0000_007F,2'b00};

    rst = 1'b0; req_EX = 1'b0; is_mem_EX = 1'b0; we_EX = 1'b0; size_EX = 2'd0;
    signed_EX = 1'b0; addr_EX = 32'h0; wdata_EX = 32'h0; rd_EX = 5'd0;
    dmem_ready = 1'b0; dmem_rdata = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wb_valid", 32'(wb_valid_WB), 32'd0);
    chk("rst_wb_rd",    32'(wb_rd_WB),    32'd0);
    chk("rst_wb_data",  wb_data_WB,       32'd0);
    chk("rst_fault",    32'(fault_MEM),   32'd0);
    chk("rst_dmem_req", 32'(dmem_req),    32'd0);
    chk("rst_dmem_we",  32'(dmem_we),     32'd0);
    chk("rst_stall",    32'(stall_MEM),   32'd0);
    rst = 1'b1;

    // ---------------- table-driven single operations ----------------
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive_op(vecs[i].is_mem, vecs[i].we, vecs[i].size, vecs[i].sgn,
               vecs[i].addr, vecs[i].wdata, vecs[i].rd);
      #1;
      chk($sformatf("v%0d_stall", i), 32'(stall_MEM), 32'(vecs[i].exp_stall));
      chk($sformatf("v%0d_req_idle", i), 32'(dmem_req), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_fault", i), 32'(fault_MEM), 32'(vecs[i].exp_fault));
      chk($sformatf("v%0d_wb_now", i), 32'(wb_valid_WB),
          32'(vecs[i].exp_wb & ~vecs[i].exp_stall));
      if (!vecs[i].exp_stall && vecs[i].exp_wb) begin
        chk($sformatf("v%0d_wb_data", i), wb_data_WB, vecs[i].exp_data);
        chk($sformatf("v%0d_wb_rd", i), 32'(wb_rd_WB), 32'(vecs[i].rd));
      end
      @(negedge clk);
      req_EX = 1'b0;
      if (vecs[i].exp_stall) begin
        #1;
        chk($sformatf("v%0d_dmem_req", i), 32'(dmem_req), 32'd1);
        chk($sformatf("v%0d_dmem_we", i), 32'(dmem_we), 32'(vecs[i].we));
        chk($sformatf("v%0d_dmem_addr", i), 32'(dmem_addr), 32'(vecs[i].addr[11:2]));
        chk($sformatf("v%0d_be", i), 32'(dmem_be), 32'(vecs[i].exp_be));
        if (vecs[i].we)
          chk($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].exp_wdata);
        dmem_ready = 1'b1;
        dmem_rdata = vecs[i].rdata;
        #1;
        chk($sformatf("v%0d_stall_rel", i), 32'(stall_MEM), 32'd0);
        @(posedge clk); #1;
        chk($sformatf("v%0d_wb", i), 32'(wb_valid_WB), 32'(vecs[i].exp_wb));
        chk($sformatf("v%0d_fault_done", i), 32'(fault_MEM), 32'd0);
        if (vecs[i].exp_wb) begin
          chk($sformatf("v%0d_wb_data", i), wb_data_WB, vecs[i].exp_data);
          chk($sformatf("v%0d_wb_rd", i), 32'(wb_rd_WB), 32'(vecs[i].rd));
        end
        @(negedge clk);
        dmem_ready = 1'b0;
        #1;
        chk($sformatf("v%0d_idle_req", i), 32'(dmem_req), 32'd0);
      end
    end

    // ---------------- signed byte load with two wait states ----------------
    @(negedge clk);
    drive_op(1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0, 5'd21);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      req_EX = 1'b0;
      #1;
      chk("ws_stall", 32'(stall_MEM), 32'd1);
      chk("ws_req",   32'(dmem_req),  32'd1);
      chk("ws_be",    32'(dmem_be),   32'b1000);
      chk("ws_addr",  32'(dmem_addr), 32'h40);
      @(posedge clk); #1;
      chk("ws_no_wb", 32'(wb_valid_WB), 32'd0);
    end
    @(negedge clk);
    dmem_ready = 1'b1; dmem_rdata = 32'h80FF_0000;
    #1;
    chk("ws_be_last", 32'(dmem_be), 32'b1000);
    chk("ws_stall_rel", 32'(stall_MEM), 32'd0);
    @(posedge clk); #1;
    chk("ws_wb_valid", 32'(wb_valid_WB), 32'd1);
    chk("ws_wb_data",  wb_data_WB, 32'hFFFF_FF80);
    chk("ws_wb_rd",    32'(wb_rd_WB), 32'd21);
    @(negedge clk);
    dmem_ready = 1'b0;

    // ---------------- timeout: ready never arrives ----------------
    begin
      int  busy_cycles;
      logic got_fault;
      busy_cycles = 0;
      got_fault   = 1'b0;
      drive_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0050, 32'h0, 5'd22);
      @(posedge clk);
      @(negedge clk);
      req_EX = 1'b0;
      for (int i = 0; i < 25 && !got_fault; i++) begin
        if (i > 0) @(negedge clk);
        #1;
        if (dmem_req) busy_cycles++;
        @(posedge clk); #1;
        if (fault_MEM != 2'b00) got_fault = 1'b1;
      end
      chk("to_seen",   32'(got_fault),   32'd1);
      chk("to_cycles", 32'(busy_cycles), 32'd15);
      chk("to_code",   32'(fault_MEM),   32'b10);
      chk("to_no_wb",  32'(wb_valid_WB), 32'd0);
      @(negedge clk);
      #1;
      chk("to_idle_req",   32'(dmem_req),  32'd0);
      chk("to_idle_stall", 32'(stall_MEM), 32'd0);
      drive_op(1'b0, 1'b0, 2'd0, 1'b0, 32'h0000_0777, 32'h0, 5'd23);
      @(posedge clk); #1;
      chk("to_next_wb",   32'(wb_valid_WB), 32'd1);
      chk("to_next_data", wb_data_WB, 32'h0000_0777);
      chk("to_fault_clr", 32'(fault_MEM), 32'd0);
      @(negedge clk);
      req_EX = 1'b0;
    end

    // ---------------- reset in second BUSY cycle, late ready ----------------
    drive_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0060, 32'h0, 5'd24);
    @(posedge clk);
    @(negedge clk);
    req_EX = 1'b0;
    #1;
    chk("rb_busy1", 32'(dmem_req), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rb_req_after", 32'(dmem_req),  32'd0);
    chk("rb_stall",     32'(stall_MEM), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    dmem_ready = 1'b1; dmem_rdata = 32'h5555_AAAA;
    #1;
    chk("rb_req_late", 32'(dmem_req), 32'd0);
    @(posedge clk); #1;
    chk("rb_no_wb",    32'(wb_valid_WB), 32'd0);
    chk("rb_no_fault", 32'(fault_MEM),   32'd0);
    @(posedge clk); #1;
    chk("rb_no_wb2",   32'(wb_valid_WB), 32'd0);
    @(negedge clk);
    dmem_ready = 1'b0;

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_mem_stage
`default_nettype wire
